// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words over a valid/ready port and
// writes them byte by byte, little-endian, into the core's instruction memory.
module imem_loader #(
   parameter int MEM_BYTES = 100,
   parameter int BASE_ADDR = 0,
   parameter int LEN_W     = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             word_valid,
   input  logic [31:0]      word_data,
   output logic             word_ready,
   output logic             mem_we,
   output logic [6:0]       mem_addr,
   output logic [7:0]       mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             cpu_hold,
   output logic [LEN_W-1:0] words_written,
   output logic [31:0]      checksum
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEPT = 3'd1,
      S_WRITE  = 3'd2,
      S_DONE   = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   localparam logic [31:0]      BASE_W   = 32'(BASE_ADDR);
   localparam logic [31:0]      MEM_W    = 32'(MEM_BYTES);
   localparam logic [6:0]       BASE_A   = 7'(BASE_ADDR);
   localparam logic [LEN_W-1:0] ONE_W    = LEN_W'(1);
   localparam logic [LEN_W-1:0] ZERO_W   = '0;

   state_t           state_reg, state_next;
   logic [LEN_W-1:0] len_reg;
   logic [6:0]       addr_reg;
   logic [1:0]       k_reg;
   logic [31:0]      word_reg;
   logic [LEN_W-1:0] ww_reg;
   logic [31:0]      cks_reg;
   logic             error_reg;
   logic             hold_reg;

   logic [31:0]      span_end;
   logic             too_long;
   logic             can_start;
   logic             start_zero;
   logic             start_err;
   logic             start_ok;
   logic             last_word;
   logic [7:0]       word_bytes [4];

   // End of the requested image, computed wide so large len cannot wrap.
   assign span_end   = BASE_W + (32'(len) << 2);
   assign too_long   = span_end > MEM_W;
   assign can_start  = start && ((state_reg == S_IDLE) || (state_reg == S_ERR));
   assign start_zero = can_start && (len == ZERO_W);
   assign start_err  = can_start && (len != ZERO_W) && too_long;
   assign start_ok   = can_start && (len != ZERO_W) && !too_long;
   assign last_word  = (ww_reg + ONE_W) == len_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
         assign word_bytes[gi] = word_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_ERR: begin
            if (start_zero) begin
               state_next = S_DONE;
            end else if (start_err) begin
               state_next = S_ERR;
            end else if (start_ok) begin
               state_next = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (word_valid) begin
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            if (k_reg == 2'd3) begin
               state_next = last_word ? S_DONE : S_ACCEPT;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Session datapath. A failed range check also re-asserts cpu_hold, since
   // the memory contents can no longer be trusted.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_reg   <= '0;
         addr_reg  <= '0;
         k_reg     <= '0;
         word_reg  <= '0;
         ww_reg    <= '0;
         cks_reg   <= '0;
         error_reg <= 1'b0;
         hold_reg  <= 1'b1;
      end else begin
         case (state_reg)
            S_IDLE, S_ERR: begin
               if (start_err) begin
                  error_reg <= 1'b1;
                  hold_reg  <= 1'b1;
               end else if (start_ok) begin
                  len_reg   <= len;
                  addr_reg  <= BASE_A;
                  ww_reg    <= '0;
                  cks_reg   <= '0;
                  error_reg <= 1'b0;
                  hold_reg  <= 1'b1;
               end
            end
            S_ACCEPT: begin
               if (word_valid) begin
                  word_reg <= word_data;
                  cks_reg  <= cks_reg ^ word_data;
                  k_reg    <= 2'd0;
               end
            end
            S_WRITE: begin
               k_reg <= k_reg + 2'd1;
               if (k_reg == 2'd3) begin
                  ww_reg   <= ww_reg + ONE_W;
                  addr_reg <= addr_reg + 7'd4;
               end
            end
            S_DONE: begin
               hold_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      word_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_reg)
         S_ACCEPT: begin
            word_ready = 1'b1;
            busy       = 1'b1;
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_reg + 7'(k_reg);
            mem_wdata = word_bytes[k_reg];
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign error         = error_reg;
   assign cpu_hold      = hold_reg;
   assign words_written = ww_reg;
   assign checksum      = cks_reg;

endmodule
